// File: rtl/bcd_stopwatch.sv
// BCD stopwatch: edge-detects divided_Clock into ticks and counts them under start/stop, lap, clear control.
// Optional SEVEN_SEG_EN adds a registered active-low seven-segment decode output (seg_Out).
module bcd_stopwatch #(
    parameter int unsigned DIGITS    = 4,
    parameter bit          ROLL_OVER = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                divided_Clock,
    input  logic                start_Stop,
    input  logic                lap,
    input  logic                clear,
    output logic [4*DIGITS-1:0] bcd_Count,
    output logic                running,
    output logic                overflow
`ifdef SEVEN_SEG_EN
    ,
    output logic [7*DIGITS-1:0] seg_Out
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_btn_sync1;
    logic [2:0]           r_btn_sync2;
    logic [2:0]           r_btn_prev;
    logic [2:0]           w_press;
    logic                 r_div_q;
    logic                 w_tick;
    logic [4*DIGITS-1:0]  r_count;
    logic [4*DIGITS-1:0]  r_lap;
    logic [4*DIGITS-1:0]  w_inc;
    logic [4*DIGITS-1:0]  w_count_next;
    logic                 w_all_nines;
    logic                 r_ovf;
    logic                 w_ovf_next;

    // Sync/prev flops reset high so a level held through reset is not seen as a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_sync1 <= '1;
            r_btn_sync2 <= '1;
            r_btn_prev  <= '1;
            r_div_q     <= 1'b1;
        end else begin
            r_btn_sync1 <= {clear, lap, start_Stop};
            r_btn_sync2 <= r_btn_sync1;
            r_btn_prev  <= r_btn_sync2;
            r_div_q     <= divided_Clock;
        end
    end

    assign w_press = r_btn_sync2 & ~r_btn_prev;
    assign w_tick  = divided_Clock & ~r_div_q;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_press[0]) w_state_next = RUN;
            RUN: begin
                if (w_press[0])      w_state_next = STOP;
                else if (w_press[1]) w_state_next = LAP;
            end
            LAP: begin
                if (w_press[0])      w_state_next = STOP;
                else if (w_press[1]) w_state_next = RUN;
            end
            STOP: begin
                if (w_press[2])      w_state_next = IDLE;
                else if (w_press[0]) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        running   = (r_state == RUN) || (r_state == LAP);
        bcd_Count = (r_state == LAP) ? r_lap : r_count;
    end

    assign overflow = r_ovf;

    always_comb begin : p_inc
        logic carry;
        carry = 1'b1;
        w_inc = r_count;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        w_all_nines = carry;
    end

    // Increment is gated by the current state, so a tick on the stop edge still counts.
    always_comb begin
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        if (((r_state == RUN) || (r_state == LAP)) && w_tick) begin
            if (w_all_nines) begin
                w_ovf_next = 1'b1;
                if (ROLL_OVER) w_count_next = '0;
            end else begin
                w_count_next = w_inc;
            end
        end else if ((r_state == STOP) && (w_state_next == IDLE)) begin
            w_count_next = '0;
            w_ovf_next   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_lap   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            if ((r_state != LAP) && (w_state_next == LAP)) r_lap <= w_count_next;
        end
    end

`ifdef SEVEN_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_Out <= '1;
        end else begin
            for (int unsigned i = 0; i < DIGITS; i++)
                seg_Out[7*i +: 7] <= seg7(bcd_Count[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: a sample-history reference model queues expected outputs per edge,
// a monitor pops and compares. Covers both ROLL_OVER settings; checks seg_Out when SEVEN_SEG_EN is defined.
module tb_bcd_stopwatch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        divided_Clock = 1'b0;
    logic        start_Stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] bcd_r, bcd_s;
    logic        run_r, run_s, ovf_r, ovf_s;
`ifdef SEVEN_SEG_EN
    logic [27:0] seg_r, seg_s;
`endif

    always #5 clock = ~clock;

    bcd_stopwatch #(.DIGITS(4), .ROLL_OVER(1'b1)) u_roll (
        .clock(clock), .reset(reset), .divided_Clock(divided_Clock),
        .start_Stop(start_Stop), .lap(lap), .clear(clear),
        .bcd_Count(bcd_r), .running(run_r), .overflow(ovf_r)
`ifdef SEVEN_SEG_EN
        , .seg_Out(seg_r)
`endif
    );

    bcd_stopwatch #(.DIGITS(4), .ROLL_OVER(1'b0)) u_sat (
        .clock(clock), .reset(reset), .divided_Clock(divided_Clock),
        .start_Stop(start_Stop), .lap(lap), .clear(clear),
        .bcd_Count(bcd_s), .running(run_s), .overflow(ovf_s)
`ifdef SEVEN_SEG_EN
        , .seg_Out(seg_s)
`endif
    );

    typedef struct {
        logic [15:0] bcd_r;
        logic [15:0] bcd_s;
        logic        run;
        logic        ovf_r;
        logic        ovf_s;
`ifdef SEVEN_SEG_EN
        logic [27:0] seg_r;
        logic [27:0] seg_s;
`endif
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: mode plus plain integer counts; outputs converted to BCD only when queued.
    typedef enum {M_IDLE, M_RUN, M_LAP, M_STOP} mode_t;
    mode_t       mode = M_IDLE;
    int          cnt_r = 0, cnt_s = 0, frz_r = 0, frz_s = 0;
    bit          mo_r = 0, mo_s = 0;
    bit [2:0]    hist [3];   // per button: [0]=last edge sample, [1]=one before, [2]=two before
    bit          d_prev = 1'b1;
    logic [15:0] prev_r = '0, prev_s = '0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] o;
        int          x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            o[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return o;
    endfunction

    function automatic logic [27:0] seg_of(input logic [15:0] b);
        logic [6:0]  tbl [10];
        logic [27:0] o;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 4; i++) o[7*i +: 7] = tbl[int'(b[4*i +: 4])];
        return o;
    endfunction

    task automatic step(input bit r, input bit s, input bit l, input bit c, input bit d);
        exp_t e;
        bit   ps, pl, pc, tk;
        @(negedge clock);
        reset = r; start_Stop = s; lap = l; clear = c; divided_Clock = d;
        if (r) begin
            mode = M_IDLE; cnt_r = 0; cnt_s = 0; frz_r = 0; frz_s = 0; mo_r = 0; mo_s = 0;
            for (int b = 0; b < 3; b++) hist[b] = 3'b111;
            d_prev = 1'b1;
        end else begin
            ps = hist[0][1] & ~hist[0][2];
            pl = hist[1][1] & ~hist[1][2];
            pc = hist[2][1] & ~hist[2][2];
            tk = d & ~d_prev;
            if ((mode == M_RUN || mode == M_LAP) && tk) begin
                cnt_r = cnt_r + 1;
                if (cnt_r == 10000) begin cnt_r = 0; mo_r = 1; end
                if (cnt_s == 9999) mo_s = 1; else cnt_s = cnt_s + 1;
            end
            case (mode)
                M_IDLE: if (ps) mode = M_RUN;
                M_RUN: begin
                    if (ps) mode = M_STOP;
                    else if (pl) begin mode = M_LAP; frz_r = cnt_r; frz_s = cnt_s; end
                end
                M_LAP: begin
                    if (ps) mode = M_STOP;
                    else if (pl) mode = M_RUN;
                end
                M_STOP: begin
                    if (pc) begin mode = M_IDLE; cnt_r = 0; cnt_s = 0; mo_r = 0; mo_s = 0; end
                    else if (ps) mode = M_RUN;
                end
            endcase
            hist[0] = {hist[0][1:0], s};
            hist[1] = {hist[1][1:0], l};
            hist[2] = {hist[2][1:0], c};
            d_prev = d;
        end
        e.bcd_r = to_bcd(mode == M_LAP ? frz_r : cnt_r);
        e.bcd_s = to_bcd(mode == M_LAP ? frz_s : cnt_s);
        e.run   = (mode == M_RUN) || (mode == M_LAP);
        e.ovf_r = mo_r;
        e.ovf_s = mo_s;
`ifdef SEVEN_SEG_EN
        e.seg_r = r ? '1 : seg_of(prev_r);
        e.seg_s = r ? '1 : seg_of(prev_s);
`endif
        prev_r = e.bcd_r;
        prev_s = e.bcd_s;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); end
    endtask

    task automatic press(input int which);
        repeat (2) step(0, which == 0, which == 1, which == 2, 0);
        idle(3);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("bcd_roll", 32'(bcd_r), 32'(e.bcd_r));
                chk("bcd_sat",  32'(bcd_s), 32'(e.bcd_s));
                chk("run_roll", 32'(run_r), 32'(e.run));
                chk("run_sat",  32'(run_s), 32'(e.run));
                chk("ovf_roll", 32'(ovf_r), 32'(e.ovf_r));
                chk("ovf_sat",  32'(ovf_s), 32'(e.ovf_s));
`ifdef SEVEN_SEG_EN
                chk("seg_roll", 32'(seg_r), 32'(e.seg_r));
                chk("seg_sat",  32'(seg_s), 32'(e.seg_s));
`endif
            end
        end
    end

    initial begin : stimulus
        bit s, l, c, d;
        // Reset with start and divided_Clock held high: no press/tick until they drop and rise again.
        repeat (3) step(1, 1, 0, 0, 1);
        repeat (6) step(0, 1, 0, 0, 1);
        idle(3);
        // Start, three ticks, then lap freeze over four ticks and lap release.
        press(0);
        ticks(3);
        ticks(2);
        press(1);
        ticks(4);
        press(1);
        ticks(2);
        // Tick coinciding with the stop press edge, then start held 100 cycles.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        repeat (50) begin step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 1); end
        idle(3);
        // Resume, clear during RUN is ignored, stop, then start+clear together in STOP.
        press(0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        ticks(3);
        press(0);
        step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
        idle(4);
        // Randomized control and tick activity.
        s = 0; l = 0; c = 0; d = 0;
        repeat (3000) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            if ($urandom_range(0, 6) == 0) l = ~l;
            if ($urandom_range(0, 7) == 0) c = ~c;
            if ($urandom_range(0, 1) == 0) d = ~d;
            step($urandom_range(0, 799) == 0, s, l, c, d);
        end
        // Reach and pass all-nines on both instances.
        step(1, 0, 0, 0, 0);
        idle(2);
        press(0);
        ticks(10250);
        press(0);
        press(2);
        // Reset while in LAP with divided_Clock and start high.
        press(0);
        ticks(2);
        press(1);
        ticks(2);
        step(0, 1, 0, 0, 1);
        repeat (2) step(1, 1, 0, 0, 1);
        repeat (6) step(0, 1, 0, 0, 1);
        idle(3);
        press(0);
        ticks(2);
        // Second random phase.
        repeat (2000) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            if ($urandom_range(0, 6) == 0) l = ~l;
            if ($urandom_range(0, 7) == 0) c = ~c;
            if ($urandom_range(0, 2) == 0) d = ~d;
            step($urandom_range(0, 999) == 0, s, l, c, d);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
